rgb_pwm_ctrl: RTL

Parametrised multi-channel LED PWM controller. It generates per-channel PWM bit streams that drive the RGBxPWM inputs of SB_RGBA_DRV. Each channel runs in one of four modes: off, solid, blink or breathe. A host configures channels at runtime over a valid/ready write port, and all outputs are clocked from hw_clk (the 12 MHz SB_HFOSC output in the top level).

---
 rtl/rgb_pwm_pkg.sv | 11 +
 rtl/rgb_pwm_chan.sv | 134 +++++++++++++
 rtl/rgb_pwm_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared mode encoding for the RGB LED PWM controller and its channels.
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: config regs, blink/breathe sequencing, frame-aligned duty and comparator.
// RGB_PWM_GAMMA_EN squares the breathe level for a perceptually linear fade.
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_W    = 8,
    parameter int PERIOD_W = 8
) (
    input  logic                hw_clk,
    input  logic                rst,
    input  logic [PWM_W-1:0]    cnt,
    input  logic                frame_end,
    input  logic                tick,
    input  logic                wr_en,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_W-1:0]    wr_duty,
    input  logic [PERIOD_W-1:0] wr_period,
    output logic                pwm
);

    mode_t                mode;
    logic [PWM_W-1:0]     duty;
    logic [PERIOD_W-1:0]  period;
    logic                 phase_on;
    logic [PERIOD_W-1:0]  phase_cnt;
    logic [PWM_W-1:0]     level;
    logic                 dir_up;
    logic [PWM_W-1:0]     eff;

    logic [PERIOD_W-1:0]  half_len;
    logic                 phase_done;
    logic [PWM_W-1:0]     level_nxt;
    logic                 dir_nxt;
    logic [PWM_W-1:0]     breathe_tgt;
    logic [PWM_W-1:0]     tgt;

    assign half_len   = (period == '0) ? PERIOD_W'(1) : period;
    assign phase_done = (phase_cnt >= half_len - PERIOD_W'(1));

`ifdef RGB_PWM_GAMMA_EN
    assign breathe_tgt = PWM_W'(({{PWM_W{1'b0}}, level} * {{PWM_W{1'b0}}, level}) >> PWM_W);
`else
    assign breathe_tgt = level;
`endif

    // NOTE: every variable gets a default before the branches, otherwise an
    // unassigned path through always_comb infers a latch.
    always_comb begin
        level_nxt = level;
        dir_nxt   = dir_up;
        if (duty == '0) begin
            level_nxt = '0;
            dir_nxt   = 1'b1;
        end else if (level > duty) begin
            level_nxt = duty;
            dir_nxt   = 1'b0;
        end else if (dir_up) begin
            if (level == duty) begin
                level_nxt = level - 1'b1;
                dir_nxt   = 1'b0;
            end else begin
                level_nxt = level + 1'b1;
            end
        end else begin
            if (level == '0) begin
                level_nxt = level + 1'b1;
                dir_nxt   = 1'b1;
            end else begin
                level_nxt = level - 1'b1;
            end
        end
    end

    always_comb begin
        tgt = '0;
        unique case (mode)
            MODE_OFF:     tgt = '0;
            MODE_SOLID:   tgt = duty;
            MODE_BLINK:   tgt = phase_on ? duty : '0;
            MODE_BREATHE: tgt = breathe_tgt;
            default:      tgt = '0;
        endcase
    end

    // NOTE: these are a handful of control flops, not a memory array, so all of
    // them are reset; a channel the host never writes must still be dark.
    always_ff @(posedge hw_clk) begin
        if (rst) begin
            mode      <= MODE_OFF;
            duty      <= '0;
            period    <= PERIOD_W'(1);
            phase_on  <= 1'b1;
            phase_cnt <= '0;
            level     <= '0;
            dir_up    <= 1'b1;
        end else if (wr_en) begin
            // A write restarts the sequence and shadows any tick in this cycle.
            mode      <= mode_t'(wr_mode);
            duty      <= wr_duty;
            period    <= wr_period;
            phase_on  <= 1'b1;
            phase_cnt <= '0;
            level     <= '0;
            dir_up    <= 1'b1;
        end else if (tick) begin
            if (mode == MODE_BLINK) begin
                if (phase_done) begin
                    phase_on  <= ~phase_on;
                    phase_cnt <= '0;
                end else begin
                    phase_cnt <= phase_cnt + 1'b1;
                end
            end
            if (mode == MODE_BREATHE) begin
                level  <= level_nxt;
                dir_up <= dir_nxt;
            end
        end
    end

    // eff only follows tgt at the frame boundary so a frame is never cut short.
    always_ff @(posedge hw_clk) begin
        if (rst) begin
            eff <= '0;
            pwm <= 1'b0;
        end else begin
            if (frame_end) begin
                eff <= tgt;
            end
            pwm <= (cnt < eff);
        end
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel LED PWM controller top: frame counter, tick prescaler, config decode, strobes.
// Optional gamma shaping of the breathe fade is enabled with RGB_PWM_GAMMA_EN.
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter  int NUM_CH    = 3,
    parameter  int PWM_W     = 8,
    parameter  int PRESC_DIV = 183,
    parameter  int PERIOD_W  = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                hw_clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_W-1:0]    cfg_duty,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic                frame_strobe,
    output logic                tick_strobe
);

    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    logic [PWM_W-1:0]   cnt;
    logic [PRESC_W-1:0] presc;
    logic               frame_end;
    logic               presc_wrap;
    logic               cfg_accept;

    assign frame_end  = (cnt == '1);
    assign presc_wrap = (presc == PRESC_W'(PRESC_DIV - 1));
    assign cfg_accept = cfg_valid && cfg_ready;

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge hw_clk) begin
        if (rst) begin
            cnt          <= '0;
            presc        <= '0;
            frame_strobe <= 1'b0;
            tick_strobe  <= 1'b0;
            cfg_ready    <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            frame_strobe <= frame_end;
            tick_strobe  <= frame_end && presc_wrap;
            cfg_ready    <= 1'b1;
            if (frame_end) begin
                presc <= presc_wrap ? '0 : presc + 1'b1;
            end
        end
    end

    // Channel numbers at or above NUM_CH match no instance, so those writes vanish.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wr_en;
        assign wr_en = cfg_accept && (cfg_ch == CH_W'(c));

        rgb_pwm_chan #(
            .PWM_W    (PWM_W),
            .PERIOD_W (PERIOD_W)
        ) u_chan (
            .hw_clk    (hw_clk),
            .rst       (rst),
            .cnt       (cnt),
            .frame_end (frame_end),
            .tick      (tick_strobe),
            .wr_en     (wr_en),
            .wr_mode   (cfg_mode),
            .wr_duty   (cfg_duty),
            .wr_period (cfg_period),
            .pwm       (pwm_out[c])
        );
    end

endmodule
